uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling driven by an external sample_trigger strobe.
// The start bit is qualified at mid-bit; data and stop bits are sampled every 16 triggers after that point.
module uart_rx (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sample_trigger,
  input  logic       serial_data,
  output logic [7:0] data,
  output logic       valid,
  output logic       framing_error,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

  localparam logic [3:0] MID_LAST = 4'd7;   // 8th low sample, counting the detection sample
  localparam logic [3:0] BIT_LAST = 4'd15;  // 16th trigger: one full bit later
  localparam logic [2:0] IDX_LAST = 3'd7;

  state_t     state, state_next;
  logic       sync1, rx_s;
  logic [3:0] cnt, cnt_next;
  logic [2:0] bit_idx, bit_idx_next;
  logic [7:0] shift, shift_next;
  logic [7:0] data_next;
  logic       valid_next, fe_next;

  // Two-flop synchronizer for the asynchronous line; idles at mark.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= serial_data;
      rx_s  <= sync1;
    end
  end

  // Next-state logic; nothing advances between sample triggers.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    bit_idx_next = bit_idx;
    shift_next   = shift;
    data_next    = data;
    valid_next   = 1'b0;
    fe_next      = 1'b0;
    if (sample_trigger) begin
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state_next = START;
            cnt_next   = 4'd1;
          end else begin
            cnt_next = 4'd0;
          end
        end
        START: begin
          if (cnt == MID_LAST) begin
            cnt_next     = 4'd0;
            bit_idx_next = 3'd0;
            if (!rx_s) begin
              state_next = DATA;
            end else begin
              state_next = IDLE;
            end
          end else begin
            cnt_next = cnt + 4'd1;
          end
        end
        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt_next            = 4'd0;
            shift_next[bit_idx] = rx_s;
            if (bit_idx == IDX_LAST) begin
              state_next = STOP;
            end else begin
              bit_idx_next = bit_idx + 3'd1;
            end
          end else begin
            cnt_next = cnt + 4'd1;
          end
        end
        STOP: begin
          // Leaving at stop mid-bit leaves half a bit to catch a back-to-back start edge.
          if (cnt == BIT_LAST) begin
            cnt_next = 4'd0;
            if (rx_s) begin
              data_next  = shift;
              valid_next = 1'b1;
              state_next = IDLE;
            end else begin
              fe_next    = 1'b1;
              state_next = WAIT_IDLE;
            end
          end else begin
            cnt_next = cnt + 4'd1;
          end
        end
        WAIT_IDLE: begin
          if (rx_s) begin
            state_next = IDLE;
            cnt_next   = 4'd0;
          end else begin
            cnt_next = 4'd0;
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = 4'd0;
        end
      endcase
    end else begin
      state_next = state;
    end
  end

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= 4'd0;
      bit_idx       <= 3'd0;
      shift         <= 8'h00;
      data          <= 8'h00;
      valid         <= 1'b0;
      framing_error <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_next;
      cnt           <= cnt_next;
      bit_idx       <= bit_idx_next;
      shift         <= shift_next;
      data          <= data_next;
      valid         <= valid_next;
      framing_error <= fe_next;
      busy          <= (state_next != IDLE);
    end
  end

endmodule
